mix_columns_seq: RTL and testbench
==================================

# mix_columns_seq

Iterative AES MixColumns engine for the encryption datapath. It is the forward counterpart of the existing combinational InvMixColumns.
- Takes a 128-bit AES state over a valid/ready handshake.
- Transforms one 32-bit column per clock over four cycles.
- Presents the result over a second valid/ready handshake.

It sits between ShiftRows and AddRoundKey in the sequential round pipeline, trading throughput for one quarter of the GF(2^8) logic.

## Interface
Parameters: none (AES-128 state width fixed at 128).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  state_in holds a state to transform
- in_ready  out  1  block can accept a state this cycle
- state_in  in  [0:127]  input state, column-major; byte k = state_in[8k +: 8]; column c = bytes 4c..4c+3, row 0 first
- out_valid  out  1  state_out holds a completed result
- out_ready  in  1  downstream accepts state_out this cycle
- state_out  out  [0:127]  MixColumns(state_in), same byte ordering

## Operation
- FSM states: IDLE, BUSY, DONE. A 2-bit column counter col_idx is used in BUSY.
- **IDLE:** in_ready=1, out_valid=0.
  - Edge with in_valid=1: latch state_in into the working register, clear col_idx, go to BUSY.
- **BUSY:** in_ready=0, out_valid=0.
  - Each edge: write column col_idx of the result register from mix_column_word(working column col_idx), then increment col_idx.
  - Edge with col_idx=3: col_idx wraps to 0, go to DONE.
- **DONE:** out_valid=1, state_out = result register.
  - in_ready = out_ready, so a back-to-back transfer is allowed.
  - Edge with out_ready=1 and in_valid=0: go to IDLE.
  - Edge with out_ready=1 and in_valid=1: result consumed and new state latched on the same edge; go to BUSY with col_idx=0.
  - Edge with out_ready=0: hold; state_out and out_valid stay stable; in_valid is ignored.
- **Column math** (a0..a3 = rows 0..3, GF(2^8), polynomial 0x11B):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xtime(x)^x.
  - All arithmetic is 8-bit XOR; no carries or widening.
- **Input capture:** state_in is sampled only on the accept edge. Changes afterwards do not affect the in-flight result.

## Timing
- **Reset values:** state=IDLE, col_idx=0, in_ready=1, out_valid=0, state_out=128'h0.
- **Latency:**
  - Accept edge E0, columns computed on E1..E4.
  - out_valid is high in the cycle following E4, i.e. 4 cycles after acceptance.
  - With out_ready tied high, throughput is 1 state per 5 cycles.
- **Output signals:**
  - in_ready and out_valid are decoded from the state register, with no combinational path from in_valid to in_ready.
  - in_ready depends combinationally on out_ready in DONE only.
- **Reset mid-operation:** rst_n low at any time aborts immediately (asynchronous). Outputs return to reset values and any in-flight result is discarded.
- **Data validity:** state_out is defined only while out_valid=1; benches check it only then.

## Structure
- **Package aes_pkg:**
  - typedef aes_state_t = logic [0:127]
  - typedef aes_word_t = logic [0:31]
  - constant AES_POLY = 8'h1B
  - functions xtime and gmul3
  - FSM enum mcs_state_e {IDLE, BUSY, DONE}
  - InvMixColumns should migrate to the same xtime.
- **Sub-module mix_column_word:** combinational, aes_word_t in to aes_word_t out, one instance.
- **Top-level contents:** FSM, col_idx, working register, result register, column mux/demux.

## Test plan
- **Single column vectors**, fed as full states (each vector replicated in all four columns):
  - db135345 -> 8e4da1bc
  - f20a225c -> 9fdc589d
  - 01010101 -> 01010101
  - c6c6c6c6 -> c6c6c6c6
  - d4d4d4d5 -> d5d5d7d6
  - 2d26314c -> 4d7ebdf8
- **FIPS-197 round 1 vector:**
  - state_in d4bf5d30e0b452aeb84111f11e2798e5 -> state_out 046681e5e0cb199a48f8d37a2806264c.
  - out_valid rises exactly 4 cycles after the accept edge.
  - Feeding this output to InvMixColumns returns the original input.
- **Backpressure:**
  - Hold out_ready=0 for 10 cycles in DONE.
  - Required: state_out stable, in_ready=0, and in_valid pulses ignored.
  - Then out_ready=1 for one cycle: transfer occurs and the block returns to IDLE.
- **Back-to-back:**
  - in_valid and out_ready held high with two different states queued.
  - Required: second state accepted on the same edge as the first result is consumed; results are in order, spaced 5 cycles apart.
- **Reset mid-BUSY:**
  - Assert rst_n=0 asynchronously while col_idx=2.
  - Required: out_valid=0, in_ready=1, state_out=0 immediately.
  - A subsequent state is transformed correctly with nominal latency.
- **Input perturbation:** change state_in on every cycle during BUSY -> result equals MixColumns of the value present at the accept edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath.
// InvMixColumns should move onto this same xtime so both directions share one definition.
package aes_pkg;

   typedef logic [0:127] aes_state_t;
   typedef logic [0:31]  aes_word_t;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mcs_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction

endpackage

// File: rtl/mix_column_word.sv
// One MixColumns column: 32-bit word in, 32-bit word out, purely combinational.
// Row 0 occupies the leftmost byte of both words.
module mix_column_word
   import aes_pkg::*;
(
   input  aes_word_t i_word,
   output aes_word_t o_word
);

   logic [7:0] w_a0, w_a1, w_a2, w_a3;
   logic [7:0] w_b0, w_b1, w_b2, w_b3;

   assign w_a0 = i_word[0:7];
   assign w_a1 = i_word[8:15];
   assign w_a2 = i_word[16:23];
   assign w_a3 = i_word[24:31];

   assign w_b0 = xtime(w_a0) ^ gmul3(w_a1) ^ w_a2        ^ w_a3;
   assign w_b1 = w_a0        ^ xtime(w_a1) ^ gmul3(w_a2) ^ w_a3;
   assign w_b2 = w_a0        ^ w_a1        ^ xtime(w_a2) ^ gmul3(w_a3);
   assign w_b3 = gmul3(w_a0) ^ w_a1        ^ w_a2        ^ xtime(w_a3);

   assign o_word = {w_b0, w_b1, w_b2, w_b3};

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns: one column per clock, result valid 4 cycles after accept.
// Holds the result under out_ready=0; in DONE a new state is accepted only as the result leaves.
module mix_columns_seq
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  aes_state_t state_in,
   output logic       out_valid,
   input  logic       out_ready,
   output aes_state_t state_out
);

   mcs_state_e r_state;
   logic [1:0] r_col_idx;
   aes_state_t r_work;
   aes_state_t r_result;
   logic [6:0] w_col_base;
   aes_word_t  w_col_in;
   aes_word_t  w_col_out;

   assign w_col_base = {r_col_idx, 5'b0};
   assign w_col_in   = r_work[w_col_base +: 32];

   mix_column_word u_mix_column_word (
      .i_word (w_col_in),
      .o_word (w_col_out)
   );

   // Readiness comes from the state register; out_ready only matters while a result waits.
   assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign out_valid = (r_state == DONE);
   assign state_out = r_result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_col_idx <= 2'd0;
         r_work    <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_work    <= state_in;
                  r_col_idx <= 2'd0;
                  r_state   <= BUSY;
               end
            end
            BUSY: begin
               r_result[w_col_base +: 32] <= w_col_out;
               r_col_idx                  <= r_col_idx + 2'd1;
               if (r_col_idx == 2'd3) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  if (in_valid) begin
                     r_work    <= state_in;
                     r_col_idx <= 2'd0;
                     r_state   <= BUSY;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and random checks of mix_columns_seq against a GF(2^8) matrix-product model.
module tb_mix_columns_seq;
   import aes_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   aes_state_t state_in = '0;
   logic       in_ready;
   logic       out_valid;
   aes_state_t state_out;

   int n_assert = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mix_columns_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out)
   );

   // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Circulant matrix times each column; inv selects the InvMixColumns matrix.
   function automatic aes_state_t matmul(input aes_state_t s, input bit inv);
      logic [7:0] base [4];
      aes_state_t o = '0;
      logic [7:0] acc;
      if (inv) base = '{8'd14, 8'd11, 8'd13, 8'd9};
      else     base = '{8'd2, 8'd3, 8'd1, 8'd1};
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               acc = acc ^ gmul(s[32*c + 8*j +: 8], base[(j - r + 4) % 4]);
            end
            o[32*c + 8*r +: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic aes_state_t rand_state();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offers s, then scrambles state_in every cycle until the result appears.
   task automatic run_one(input aes_state_t s, output aes_state_t got, output int lat);
      int w;
      w = 0;
      @(negedge clk);
      state_in  = s;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("accept_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         state_in = rand_state();
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      got = state_out;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      aes_state_t got, s, a, b, snap;
      aes_state_t res [2];
      int lat, nres, t [2], cyc;
      bit drop_next;
      logic [31:0] vin [6];
      logic [31:0] vout [6];

      vin  = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
      vout = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};

      #12 ;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_state_out", state_out, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_one({4{vin[i]}}, got, lat);
         check($sformatf("col_vec%0d", i), got, {4{vout[i]}});
         drain();
      end

      s = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      run_one(s, got, lat);
      check("fips_result", got, 128'h046681e5e0cb199a48f8d37a2806264c);
      check("fips_latency", lat, 4);
      check("fips_inverse", matmul(got, 1'b1), s);
      drain();

      for (int i = 0; i < 8; i++) begin
         s = rand_state();
         run_one(s, got, lat);
         check($sformatf("rand%0d", i), got, matmul(s, 1'b0));
         check($sformatf("rand%0d_lat", i), lat, 4);
         drain();
      end

      // Backpressure: result must hold and in_valid must be ignored.
      s = rand_state();
      run_one(s, got, lat);
      check("bp_result", got, matmul(s, 1'b0));
      snap = got;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         state_in = rand_state();
         @(posedge clk);
         @(negedge clk);
         check("bp_stable", state_out, snap);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      drain();

      // Back-to-back: second state queued while the first result drains.
      a = rand_state();
      b = rand_state();
      @(negedge clk);
      state_in  = a;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      state_in  = b;
      nres      = 0;
      cyc       = 0;
      drop_next = 1'b0;
      while (nres < 2 && cyc < 40) begin
         if (drop_next) begin
            in_valid  = 1'b0;
            drop_next = 1'b0;
         end
         if (out_valid) begin
            res[nres] = state_out;
            t[nres]   = cyc;
            if (nres == 0) begin
               check("b2b_same_edge_ready", in_ready, 1);
               drop_next = 1'b1;
            end
            nres++;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      check("b2b_count", nres, 2);
      check("b2b_first", res[0], matmul(a, 1'b0));
      check("b2b_second", res[1], matmul(b, 1'b0));
      check("b2b_spacing", t[1] - t[0], 5);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("b2b_idle", in_ready, 1);

      // Asynchronous reset with col_idx at 2.
      @(negedge clk);
      state_in = rand_state();
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 ;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_state_out", state_out, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      s = rand_state();
      run_one(s, got, lat);
      check("postrst_result", got, matmul(s, 1'b0));
      check("postrst_latency", lat, 4);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
